// File: rtl/max_pool_multi9.sv
// Multi-channel FP16 max-pool, 9x9 window / stride 9. One channel per clock goes
// through a shared comparator tree; pooled results land in a registered output map.
module max_pool_multi9 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 2,
  parameter int unsigned H          = 9,
  parameter int unsigned W          = 9
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [0:H*W*D*DATA_WIDTH-1]           mpInput,
  output logic [0:(H/9)*(W/9)*D*DATA_WIDTH-1]   mpOutput
);

  localparam int unsigned s      = 9;
  localparam int unsigned HO     = H / s;
  localparam int unsigned WO     = W / s;
  localparam int unsigned NWIN   = HO * WO;
  localparam int unsigned WIN_N  = s * s;
  localparam int unsigned LV     = $clog2(WIN_N);
  localparam int unsigned NP     = 1 << LV;
  localparam int unsigned CH_W   = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned MAP_W  = H * W * DATA_WIDTH;
  localparam int unsigned MAG_W  = DATA_WIDTH - 1;

  logic [CH_W-1:0]              ch;
  logic [0:MAP_W-1]             ch_map;
  logic [NWIN*DATA_WIDTH-1:0]   win_flat;

  // Strict "a beats b" under sign-magnitude ordering; +0 and -0 compare equal.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                              input logic [DATA_WIDTH-1:0] b);
    logic             sa;
    logic             sb;
    logic [MAG_W-1:0] ma;
    logic [MAG_W-1:0] mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[MAG_W-1:0];
    mb = b[MAG_W-1:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (sa != sb)             return ~sa;
    if (!sa)                  return (ma > mb);
    return (ma < mb);
  endfunction

  // Select the active channel's feature map.
  always_comb begin
    ch_map = '0;
    for (int unsigned d = 0; d < D; d++) begin
      if (ch == CH_W'(d)) ch_map = mpInput[d*MAP_W +: MAP_W];
    end
  end

  for (genvar wi = 0; wi < NWIN; wi++) begin : g_win
    localparam int unsigned WR = wi / WO;
    localparam int unsigned WC = wi % WO;

    logic [DATA_WIDTH-1:0] best;

    // Balanced tree; on a tie the left (lower-indexed) operand is kept.
    always_comb begin : p_tree
      logic [DATA_WIDTH-1:0] val [0:LV][0:NP-1];
      logic                  vld [0:LV][0:NP-1];
      for (int unsigned l = 0; l <= LV; l++) begin
        for (int unsigned i = 0; i < NP; i++) begin
          val[l][i] = '0;
          vld[l][i] = 1'b0;
        end
      end
      for (int unsigned k = 0; k < WIN_N; k++) begin
        val[0][k] = ch_map[((WR*s + k/s)*W + WC*s + k%s)*DATA_WIDTH +: DATA_WIDTH];
        vld[0][k] = 1'b1;
      end
      for (int unsigned l = 0; l < LV; l++) begin
        for (int unsigned i = 0; i < NP/2; i++) begin
          if (vld[l][2*i+1] && gt(val[l][2*i+1], val[l][2*i])) begin
            val[l+1][i] = val[l][2*i+1];
            vld[l+1][i] = 1'b1;
          end else begin
            val[l+1][i] = val[l][2*i];
            vld[l+1][i] = vld[l][2*i];
          end
        end
      end
      best = val[LV][0];
    end

    assign win_flat[wi*DATA_WIDTH +: DATA_WIDTH] = best;
  end

  // Write the active channel's slice, then advance the channel pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mpOutput <= '0;
      ch       <= '0;
    end else begin
      for (int unsigned d = 0; d < D; d++) begin
        if (ch == CH_W'(d)) begin
          for (int unsigned w = 0; w < NWIN; w++) begin
            mpOutput[(d*NWIN + w)*DATA_WIDTH +: DATA_WIDTH] <= win_flat[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      ch <= (ch == CH_W'(D-1)) ? '0 : CH_W'(ch + 1'b1);
    end
  end

endmodule

// File: tb/tb_max_pool_multi9.sv
// Directed bench for max_pool_multi9 with default parameters (2 channels, 9x9 map).
module tb_max_pool_multi9;

  localparam int unsigned DW   = 16;
  localparam int unsigned D    = 2;
  localparam int unsigned H    = 9;
  localparam int unsigned W    = 9;
  localparam int unsigned IN_W = H * W * D * DW;

  logic            clk;
  logic            reset;
  logic [0:IN_W-1] mp_input;
  logic [0:D*DW-1] mp_output;

  int tests;
  int failed;

  max_pool_multi9 #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .mpInput  (mp_input),
    .mpOutput (mp_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_ch(input int d, input logic [DW-1:0] v);
    for (int k = 0; k < H*W; k++) mp_input[(d*H*W + k)*DW +: DW] = v;
  endtask

  task automatic set_elem(input int d, input int k, input logic [DW-1:0] v);
    mp_input[(d*H*W + k)*DW +: DW] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    reset    = 1'b1;
    mp_input = '0;

    // Reset state
    fill_ch(0, 16'h4000);
    fill_ch(1, 16'h4000);
    tick(2);
    check("reset_zero", mp_output, 32'h0000_0000);

    // Positive values, one max per channel, latency per channel
    set_elem(0, 40, 16'h4500);
    set_elem(0, 10, 16'h4200);
    set_elem(1, 5,  16'h4500);
    set_elem(1, 70, 16'h4200);
    reset = 1'b0;
    tick(1);
    check("lat_ch0_only", mp_output, 32'h4500_0000);
    tick(1);
    check("lat_both", mp_output, 32'h4500_4500);

    // Negatives; -0 at index 0 wins the tie with +0
    fill_ch(0, 16'hBC00);
    set_elem(0, 33, 16'hB800);
    fill_ch(1, 16'h8000);
    set_elem(1, 30, 16'h0000);
    tick(2);
    check("neg_and_zero_tie", mp_output, 32'hB800_8000);

    // Max at first element of ch0 and last element of ch1
    fill_ch(0, 16'h3C00);
    fill_ch(1, 16'h3C00);
    set_elem(0, 0,  16'h7BFF);
    set_elem(1, 80, 16'h7BFF);
    tick(2);
    check("edge_positions", mp_output, 32'h7BFF_7BFF);

    // +0 beats negatives; ch1 -0 vs +0 tie keeps index 0
    fill_ch(0, 16'h8400);
    set_elem(0, 45, 16'h0000);
    fill_ch(1, 16'h0000);
    set_elem(1, 0, 16'h8000);
    tick(2);
    check("zero_vs_neg", mp_output, 32'h0000_8000);

    // Mixed signs with -inf background; ch1 NaN pattern beats +inf by magnitude
    fill_ch(0, 16'hFC00);
    set_elem(0, 3,  16'hC500);
    set_elem(0, 60, 16'h0001);
    fill_ch(1, 16'h3C00);
    set_elem(1, 2,  16'h7C00);
    set_elem(1, 77, 16'h7E00);
    tick(2);
    check("mixed_sign_nan", mp_output, 32'h0001_7E00);

    // Live input change reaches every slice within D cycles
    set_elem(1, 77, 16'h3C00);
    tick(2);
    check("live_update", mp_output, 32'h0001_7C00);

    // Reset from a full output, then sweep order restarts at ch0
    reset = 1'b1;
    tick(1);
    check("reset_full", mp_output, 32'h0000_0000);
    reset = 1'b0;
    tick(1);
    check("restart_ch0", mp_output, 32'h0001_0000);

    // Reset one edge into a sweep
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("sweep_first_edge", mp_output, 32'h0001_0000);
    reset = 1'b1;
    tick(1);
    check("mid_sweep_reset", mp_output, 32'h0000_0000);
    reset = 1'b0;
    tick(1);
    check("mid_sweep_restart", mp_output, 32'h0001_0000);
    tick(1);
    check("mid_sweep_complete", mp_output, 32'h0001_7C00);

    // Single negative max among -inf: smaller magnitude wins
    fill_ch(0, 16'hFC00);
    set_elem(0, 50, 16'hC500);
    fill_ch(1, 16'hFC00);
    tick(2);
    check("all_negative", mp_output, 32'hC500_FC00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
